// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared scanner state type and width helpers
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index width for n items, never below one bit.
    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width able to hold the value max_count itself.
    function automatic int count_width(input int max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// key_fifo : small key-code FIFO with registered storage and sticky drop flag
// Revision : 1.0
// ============================================================================
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);
    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             full, do_pop, do_push, drop;

    assign valid_o    = (count_q != '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i & valid_o;
    // A pop in the same cycle frees the slot, so push-while-full still lands.
    assign do_push    = push_i & (~full | do_pop);
    assign drop       = push_i & full & ~do_pop;
    assign data_o     = valid_o ? mem_q[rd_q] : '0;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)       ovf_q <= 1'b1;
            else if (clr_i) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : row-strobed matrix keypad scanner with debounce, optional
//                  auto-repeat and a key-code FIFO behind valid/ready
// Revision       : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEB_TICKS    = 20,
    parameter int REPEAT_TICKS = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               fil,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int CW  = $clog2(ROWS * COLS);
    localparam int RW  = code_width(ROWS);
    localparam int CLW = code_width(COLS);
    localparam int TW  = $clog2(SCAN_DIV);
    localparam int DW  = count_width(DEB_TICKS);
    localparam int PW  = count_width(REPEAT_TICKS);

    logic [TW-1:0]   div_q;
    logic            tick;
    logic [COLS-1:0] sync1_q, sync2_q;
    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d, row_nxt;
    logic [COLS-1:0] cap_q, cap_d;
    logic [CLW-1:0]  capcol_q, capcol_d, hit_col;
    logic [DW-1:0]   deb_q, deb_d, rel_q, rel_d;
    logic [PW-1:0]   rep_q, rep_d;
    logic            single_hit, held_bit, push;
    logic [CW-1:0]   push_code;

    assign tick = (div_q == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
        end
    end

    assign single_hit = $onehot(sync2_q);
    assign held_bit   = |(sync2_q & cap_q);
    assign row_nxt    = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;

    always_comb begin
        hit_col = '0;
        for (int c = 0; c < COLS; c++) begin
            if (sync2_q[c]) hit_col = CLW'(c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            cap_q    <= '0;
            capcol_q <= '0;
            deb_q    <= '0;
            rel_q    <= '0;
            rep_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cap_q    <= cap_d;
            capcol_q <= capcol_d;
            deb_q    <= deb_d;
            rel_q    <= rel_d;
            rep_q    <= rep_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cap_d    = cap_q;
        capcol_d = capcol_q;
        deb_d    = deb_q;
        rel_d    = rel_q;
        rep_d    = rep_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (single_hit) begin
                        cap_d    = sync2_q;
                        capcol_d = hit_col;
                        deb_d    = DW'(1);
                        rel_d    = '0;
                        rep_d    = '0;
                        state_d  = (DEB_TICKS == 1) ? HELD : DEBOUNCE;
                    end else begin
                        row_d = row_nxt;
                    end
                end
                DEBOUNCE: begin
                    if (sync2_q == cap_q) begin
                        deb_d = deb_q + 1'b1;
                        if (deb_q + 1'b1 == DW'(DEB_TICKS)) begin
                            state_d = HELD;
                            rep_d   = '0;
                            rel_d   = '0;
                        end
                    end else begin
                        row_d   = row_nxt;
                        deb_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!held_bit) begin
                        rel_d = rel_q + 1'b1;
                        if (rel_q + 1'b1 == DW'(DEB_TICKS)) begin
                            row_d   = row_nxt;
                            rel_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        rel_d = '0;
                        if (REPEAT_TICKS > 0) begin
                            rep_d = (rep_q + 1'b1 == PW'(REPEAT_TICKS)) ? '0 : rep_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The push decision mirrors the transitions above that accept or repeat a key.
    always_comb begin
        fil        = '0;
        fil[row_q] = 1'b1;
        push       = 1'b0;
        push_code  = CW'(int'(row_q) * COLS + int'((state_q == IDLE) ? hit_col : capcol_q));
        if (tick) begin
            case (state_q)
                IDLE:     push = single_hit && (DEB_TICKS == 1);
                DEBOUNCE: push = (sync2_q == cap_q) && (deb_q + 1'b1 == DW'(DEB_TICKS));
                HELD:     push = held_bit && (REPEAT_TICKS > 0)
                                 && (rep_q + 1'b1 == PW'(REPEAT_TICKS));
                default:  push = 1'b0;
            endcase
        end
    end

    key_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .data_i     (push_code),
        .pop_i      (key_ready),
        .clr_i      (ovf_clr),
        .data_o     (key_code),
        .valid_o    (key_valid),
        .overflow_o (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed and random key presses on a modelled keypad
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;
    localparam int COLS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_m, fil_m, code_m, col_r, fil_r, code_r;
    logic       valid_m, valid_r, ovf_m, ovf_r;
    logic       ready_m = 1'b0, ready_r = 1'b1, clr_m = 1'b0;
    int         pressed = -1, pressed_r = -1, mode = 0;
    logic [3:0] ov_val = 4'b0;
    int         n_chk = 0, n_fail = 0, cyc = 0;
    int         exp_q[$];
    logic       exp_ovf = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: the pressed key shorts its column onto the strobed row.
    function automatic logic [3:0] keypad(input int k, input logic [3:0] f);
        logic [3:0] r;
        r = 4'b0;
        if (k >= 0 && f[k / COLS]) r[k % COLS] = 1'b1;
        return r;
    endfunction

    always_comb begin
        case (mode)
            1:       col_m = ov_val;
            2:       col_m = fil_m[1] ? ov_val : 4'b0;
            default: col_m = keypad(pressed, fil_m);
        endcase
    end
    always_comb col_r = keypad(pressed_r, fil_r);

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_TICKS(3),
                     .REPEAT_TICKS(0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .col(col_m), .fil(fil_m), .key_code(code_m),
        .key_valid(valid_m), .key_ready(ready_m), .overflow(ovf_m), .ovf_clr(clr_m));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_TICKS(3),
                     .REPEAT_TICKS(5), .FIFO_DEPTH(4)) dut_r (
        .clk(clk), .rst(rst), .col(col_r), .fil(fil_r), .key_code(code_r),
        .key_valid(valid_r), .key_ready(ready_r), .overflow(ovf_r), .ovf_clr(1'b0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fil(input logic [3:0] v, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (fil_m !== v && n < budget);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) chk({tag, "_extra"}, valid_m, 1'b0);
        else                   chk(tag, code_m, exp_q.pop_front());
    endtask

    // One cycle with a randomly willing consumer; a pop is checked before the edge that takes it.
    task automatic cstep();
        ready_m = 1'($urandom_range(0, 1));
        if (ready_m && valid_m) pop_check("rand_code");
        step();
    endtask

    task automatic press_release(input int k, input int hold, input int rel, input bit consume);
        pressed = k;
        repeat (hold) if (consume) cstep(); else step();
        pressed = -1;
        repeat (rel) if (consume) cstep(); else step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n, k, nrep, tprev;
        logic seen;
        logic [3:0] f0, nxt;
        int   keys[5] = '{0, 5, 10, 15, 3};

        repeat (3) step();
        chk("rst_fil", fil_m, 4'b0001);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_ovf", ovf_m, 1'b0);
        chk("rst_code", code_m, 4'd0);
        chk("rst_valid_r", valid_r, 1'b0);
        rst = 1'b0;

        wait_fil(4'b0010, 8, n); chk("rot_0010", n, 4);
        wait_fil(4'b0100, 8, n); chk("rot_0100", n, 4);
        wait_fil(4'b1000, 8, n); chk("rot_1000", n, 4);
        wait_fil(4'b0001, 8, n); chk("rot_0001", n, 4);

        // Key 9 (row 2, column 1), latency bound then exactly one code.
        pressed = 9;
        n = 0;
        while (!valid_m && n < 31) begin step(); n++; end
        chk("k9_valid_in_time", valid_m, 1'b1);
        chk("k9_code", code_m, 4'd9);
        repeat (20) step();
        pressed = -1;
        repeat (30) step();
        chk("k9_still_valid", valid_m, 1'b1);
        chk("k9_code_held", code_m, 4'd9);
        ready_m = 1'b1; step(); ready_m = 1'b0;
        chk("k9_single_code", valid_m, 1'b0);

        // Bouncing column: never three consecutive matching ticks.
        mode = 1;
        for (int i = 0; i < 10; i++) begin
            ov_val = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (4) step();
        end
        chk("bounce_no_code", valid_m, 1'b0);
        mode = 0; ov_val = 4'b0;
        f0 = fil_m; n = 0;
        do begin step(); n++; end while (fil_m === f0 && n < 12);
        chk("bounce_resume", fil_m !== f0, 1'b1);
        nxt = {fil_m[2:0], fil_m[3]};
        wait_fil(nxt, 8, n); chk("bounce_rotate", n, 4);

        // Two columns on row 1 are not a key.
        mode = 2; ov_val = 4'b0011;
        wait_fil(4'b1000, 20, n); chk("multi_reach_1000", fil_m, 4'b1000);
        wait_fil(4'b0001, 8, n);  chk("multi_rot_0001", n, 4);
        wait_fil(4'b0010, 8, n);  chk("multi_rot_0010", n, 4);
        wait_fil(4'b0100, 8, n);  chk("multi_pass_row1", n, 4);
        chk("multi_no_code", valid_m, 1'b0);
        mode = 0; ov_val = 4'b0;

        // Reset during debounce of key 4 discards it.
        wait_fil(4'b0001, 20, n);
        pressed = 4;
        wait_fil(4'b0010, 8, n);
        repeat (9) step();
        rst = 1'b1; pressed = -1;
        repeat (2) step();
        rst = 1'b0;
        chk("midrst_valid", valid_m, 1'b0);
        chk("midrst_fil", fil_m, 4'b0001);
        repeat (40) step();
        chk("midrst_no_code", valid_m, 1'b0);

        // Fill the FIFO with the consumer stalled; fifth key is dropped.
        foreach (keys[i]) begin
            press_release(keys[i], 40, 30, 1'b0);
            if (exp_q.size() < 4) exp_q.push_back(keys[i]);
            else                  exp_ovf = 1'b1;
            if (i == 3) begin
                chk("full_no_ovf", ovf_m, exp_ovf);
                chk("full_valid", valid_m, 1'b1);
            end
        end
        chk("ovf_set", ovf_m, exp_ovf);
        clr_m = 1'b1; step(); clr_m = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_cleared", ovf_m, exp_ovf);

        // Clear held high across another drop: the drop still shows.
        clr_m = 1'b1; seen = 1'b0; pressed = 12;
        repeat (40) begin step(); if (ovf_m) seen = 1'b1; end
        pressed = -1;
        repeat (30) begin step(); if (ovf_m) seen = 1'b1; end
        clr_m = 1'b0; step();
        chk("ovf_set_wins", seen, 1'b1);
        chk("ovf_after_clr", ovf_m, 1'b0);

        ready_m = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!valid_m) break;
            pop_check("drain_code");
            step();
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", valid_m, 1'b0);
        ready_m = 1'b0;

        // Random keys against a randomly stalling consumer.
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 15);
            exp_q.push_back(k);
            press_release(k, 45, 30, 1'b1);
        end
        ready_m = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!valid_m) break;
            pop_check("rand_tail");
            step();
        end
        chk("rand_left", exp_q.size(), 0);
        chk("rand_empty", valid_m, 1'b0);
        ready_m = 1'b0;

        // Auto-repeat instance: key 6 held for 17 ticks past acceptance.
        pressed_r = 6;
        n = 0;
        while (!valid_r && n < 40) begin step(); n++; end
        chk("rep_first_valid", valid_r, 1'b1);
        chk("rep_first_code", code_r, 4'd6);
        tprev = cyc; nrep = 0;
        for (int i = 1; i <= 140; i++) begin
            step();
            if (i == 68) pressed_r = -1;
            if (valid_r) begin
                nrep++;
                chk("rep_code", code_r, 4'd6);
                chk("rep_interval", cyc - tprev, 20);
                tprev = cyc;
            end
        end
        chk("rep_count", nrep, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad front end for the calculator: drives one-hot row strobes, samples column returns, debounces a single pressed key, optionally auto-repeats it, and queues key codes in a small FIFO behind a valid/ready handshake. It replaces the fixed 4x4 row sweep plus column compare of the first-generation calculator and feeds key codes to the display/operand logic.

## Interface
- ROWS, 4, number of row strobes (>=2)
- COLS, 4, number of column inputs (>=2)
- SCAN_DIV, 50000, clk cycles per scan tick (1 kHz at 50 MHz); must be >=4
- DEB_TICKS, 20, consecutive ticks needed to accept a press or a release (>=1)
- REPEAT_TICKS, 0, auto-repeat period in ticks while held; 0 disables repeat
- FIFO_DEPTH, 4, key FIFO entries, power of two >=2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- col  in  COLS  column returns, active-high, asynchronous to clk
- fil  out  ROWS  one-hot active-high row strobe
- key_code  out  $clog2(ROWS*COLS)  FIFO head, code = row*COLS + col
- key_valid  out  1  FIFO not empty
- key_ready  in  1  consumer accepts head when key_valid & key_ready
- overflow  out  1  sticky: a code was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow (single-cycle pulse)

## Operation
- Tick counter: 0..SCAN_DIV-1; tick = 1 for one cycle when counter = SCAN_DIV-1.
- col passes through a 2-flop synchroniser; all decisions use the synchronised value, sampled only on tick.
- "Single hit": synchronised col has exactly one bit set; zero or multiple bits are treated as no key.
- FSM states IDLE, DEBOUNCE, HELD:
  - IDLE: on tick, if single hit on current row -> capture row/col, cnt=1, go DEBOUNCE (row held); else advance row (ROWS-1 wraps to 0).
  - DEBOUNCE: on tick, same single bit -> cnt++; when cnt reaches DEB_TICKS, push code, rep=0, go HELD. Any other value -> advance row, go IDLE.
  - HELD: on tick, captured bit clear -> rel++, and when rel reaches DEB_TICKS -> advance row, go IDLE. Bit set -> rel=0; if REPEAT_TICKS>0, rep++, and when rep reaches REPEAT_TICKS push same code, rep=0.
  - DEB_TICKS=1: press accepted on first hit tick.
- FIFO: push at most once per cycle; pop on key_valid & key_ready. Push and pop together when full: both succeed. Push when full without pop: code dropped, overflow<=1. ovf_clr together with a drop: overflow stays 1 (set wins).
- Reset: fil = one-hot row 0, FSM IDLE, all counters 0, FIFO empty, key_valid=0, key_code=0, overflow=0, synchroniser cleared. Reset mid-debounce or mid-hold discards the pending press; no code pushed.

## Timing
- fil changes in the cycle after a tick; next sample at the following tick, giving SCAN_DIV-2 settled cycles after synchroniser latency.
- Pushed code appears on key_code with key_valid=1 one cycle after the push tick.
- Pop: head advances on the clock edge where key_valid & key_ready; next entry (if any) visible next cycle; key_valid is combinational from FIFO count, registered head.
- Worst-case press latency from stable col: (ROWS + DEB_TICKS) * SCAN_DIV + 3 cycles.

## Structure
- Package keypad_pkg: FSM state enum (IDLE, DEBOUNCE, HELD), code-width function for ROWS*COLS.
- Sub-module key_fifo (parametrised width/depth, push/pop/full/empty, drop-on-full flag). Scanner FSM, tick counter, synchroniser stay in keypad_scanner.

## Test plan
Use SCAN_DIV=4, DEB_TICKS=3, ROWS=COLS=4, FIFO_DEPTH=4 unless noted.
- Reset held 3 cycles -> fil=4'b0001, key_valid=0, overflow=0; release, no col -> fil rotates 0001,0010,0100,1000,0001 every 4 cycles.
- Hold col=4'b0010 only while fil=0100 (row 2) -> key_code=9, key_valid=1 within (4+3)*4+3 cycles; hold and release -> exactly one code; key_ready=1 pops it, key_valid=0.
- Toggle col bit every tick (bounce shorter than DEB_TICKS) -> no push, FSM returns to IDLE, rotation resumes.
- col=4'b0011 on row 1 -> ignored, no code, rotation continues.
- key_ready=0, press/release keys 0,5,10,15,3 -> FIFO holds 0,5,10,15, overflow=1; pulse ovf_clr -> overflow=0; drain with key_ready=1 -> codes in order 0,5,10,15.
- REPEAT_TICKS=5, hold key 6 for 20 ticks -> first code 6 at debounce, further 6s every 5 ticks (three repeats), none after release.
